pwm_capture: RTL and testbench

Multi-channel PWM duty-cycle decoder, the receive counterpart of the team's `pwm` generator. It samples `NB_INPUTS` PWM lines on the same prescaled tick grid as `pwm`, with a 100-tick period. Each completed period is converted back into a duty cycle in percent. Results are reported one at a time on a valid-qualified channel/duty bus that mirrors the `duty_output`/`duty_cycle`/`duty_valid` write port of `pwm`, so a loopback bench or a supervisor can check generator output directly.

---
 rtl/pwm_capture.sv | 205 ++++++++++++++++++++
 tb/tb_pwm_capture.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_capture.sv
// pwm_capture: multi-channel PWM duty-cycle decoder.
//
// Each PWM line is synchronised, then sampled on a prescaled tick grid.
// Every full period between two rising edges is turned back into a duty in
// percent. A line that stops toggling is reported as 0 % or 100 % once per
// timeout. Results are queued per channel and reported one at a time.
//
// Parameters:
//   CLK_SCALER  clocks per sampling tick
//   NB_INPUTS   number of PWM inputs (1..255)
//   PERIOD_TOL  accepted deviation in ticks from the 100-tick period
// Ports:
//   clk          sole clock, rising edge
//   rst          asynchronous, active-low reset
//   run          capture enable; low clears prescaler and channel state
//   pwm_in       asynchronous PWM lines, bit i = channel i
//   meas_output  channel index of the current report
//   meas_duty    measured duty, 0..100
//   meas_error   period outside 100 +/- PERIOD_TOL ticks
//   meas_valid   one-cycle strobe qualifying the three fields above
module pwm_capture #(
    parameter int CLK_SCALER = 100,
    parameter int NB_INPUTS  = 8,
    parameter int PERIOD_TOL = 1,
    localparam int IW = (NB_INPUTS > 1) ? $clog2(NB_INPUTS) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 run,
    input  logic [NB_INPUTS-1:0] pwm_in,
    output logic [IW-1:0]        meas_output,
    output logic [7:0]           meas_duty,
    output logic                 meas_error,
    output logic                 meas_valid
);

    localparam int PW  = (CLK_SCALER > 1) ? $clog2(CLK_SCALER) : 1;
    localparam int IWP = IW + 1;
    localparam logic [7:0] PER_MAX = 8'(100 + PERIOD_TOL);
    localparam logic [7:0] PER_MIN = 8'(100 - PERIOD_TOL);

    logic [NB_INPUTS-1:0] sync1_reg;
    logic [NB_INPUTS-1:0] sync2_reg;
    logic [PW-1:0]        presc_reg;
    logic                 tick;

    logic [NB_INPUTS-1:0]       pend_vec;
    logic [NB_INPUTS-1:0][7:0]  pduty_vec;
    logic [NB_INPUTS-1:0]       perr_vec;

    logic [IW-1:0] start_reg;
    logic [IW-1:0] grant_idx;
    logic          grant_any;

    // Two-flop synchroniser; only sync2_reg is used downstream.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_reg <= '0;
            sync2_reg <= '0;
        end else begin
            sync1_reg <= pwm_in;
            sync2_reg <= sync1_reg;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc_reg <= '0;
        end else if (!run || presc_reg == PW'(CLK_SCALER - 1)) begin
            presc_reg <= '0;
        end else begin
            presc_reg <= presc_reg + 1'b1;
        end
    end

    assign tick = run && (presc_reg == PW'(CLK_SCALER - 1));

    genvar gi;
    generate
        for (gi = 0; gi < NB_INPUTS; gi++) begin : g_ch
            logic       prev_reg, armed_reg;
            logic [7:0] per_cnt_reg, high_cnt_reg;
            logic       pend_reg, perr_reg;
            logic [7:0] pduty_reg;

            logic       rise;
            logic       hit;
            logic [7:0] duty;
            logic       err;
            logic       armed_next;
            logic [7:0] per_next, high_next;
            logic       granted;

            assign granted = grant_any && (grant_idx == IW'(gi));

            always_comb begin
                rise       = !prev_reg && sync2_reg[gi];
                hit        = 1'b0;
                duty       = 8'd0;
                err        = 1'b0;
                armed_next = armed_reg;
                per_next   = (per_cnt_reg == 8'hFF) ? 8'hFF : per_cnt_reg + 8'd1;
                high_next  = (high_cnt_reg == 8'hFF || !sync2_reg[gi]) ?
                             high_cnt_reg : high_cnt_reg + 8'd1;
                if (rise) begin
                    // The first rising edge only arms the channel.
                    hit        = armed_reg;
                    duty       = (high_cnt_reg > 8'd100) ? 8'd100 : high_cnt_reg;
                    err        = (per_cnt_reg < PER_MIN) || (per_cnt_reg > PER_MAX);
                    per_next   = 8'd1;
                    high_next  = 8'd1;
                    armed_next = 1'b1;
                end else if (per_cnt_reg >= PER_MAX) begin
                    // Incrementing would exceed the longest legal period:
                    // report the steady level and restart the window.
                    hit        = 1'b1;
                    duty       = sync2_reg[gi] ? 8'd100 : 8'd0;
                    per_next   = 8'd1;
                    high_next  = {7'd0, sync2_reg[gi]};
                    armed_next = 1'b0;
                end
            end

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    prev_reg     <= 1'b0;
                    armed_reg    <= 1'b0;
                    per_cnt_reg  <= 8'd0;
                    high_cnt_reg <= 8'd0;
                    pend_reg     <= 1'b0;
                    pduty_reg    <= 8'd0;
                    perr_reg     <= 1'b0;
                end else if (!run) begin
                    prev_reg     <= 1'b0;
                    armed_reg    <= 1'b0;
                    per_cnt_reg  <= 8'd0;
                    high_cnt_reg <= 8'd0;
                    pend_reg     <= 1'b0;
                    pduty_reg    <= 8'd0;
                    perr_reg     <= 1'b0;
                end else begin
                    if (tick) begin
                        prev_reg     <= sync2_reg[gi];
                        armed_reg    <= armed_next;
                        per_cnt_reg  <= per_next;
                        high_cnt_reg <= high_next;
                    end
                    // A fresh measurement wins over a grant in the same cycle.
                    if (tick && hit) begin
                        pend_reg  <= 1'b1;
                        pduty_reg <= duty;
                        perr_reg  <= err;
                    end else if (granted) begin
                        pend_reg <= 1'b0;
                    end
                end
            end

            assign pend_vec[gi]  = pend_reg;
            assign pduty_vec[gi] = pduty_reg;
            assign perr_vec[gi]  = perr_reg;
        end
    endgenerate

    // Round-robin search starting at start_reg (last grant + 1).
    always_comb begin
        logic [IWP-1:0] idx;
        idx       = '0;
        grant_any = 1'b0;
        grant_idx = '0;
        for (int k = 0; k < NB_INPUTS; k++) begin
            idx = {1'b0, start_reg} + IWP'(k);
            if (idx >= IWP'(NB_INPUTS)) begin
                idx = idx - IWP'(NB_INPUTS);
            end
            if (!grant_any && pend_vec[idx[IW-1:0]]) begin
                grant_any = 1'b1;
                grant_idx = idx[IW-1:0];
            end
        end
        // Pending flags are being cleared while run is low; grant nothing.
        if (!run) begin
            grant_any = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            start_reg   <= '0;
            meas_valid  <= 1'b0;
            meas_output <= '0;
            meas_duty   <= 8'd0;
            meas_error  <= 1'b0;
        end else if (grant_any) begin
            start_reg   <= (grant_idx == IW'(NB_INPUTS - 1)) ? '0 : grant_idx + 1'b1;
            meas_valid  <= 1'b1;
            meas_output <= grant_idx;
            meas_duty   <= pduty_vec[grant_idx];
            meas_error  <= perr_vec[grant_idx];
        end else begin
            meas_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pwm_capture.sv
`timescale 1ns/1ps
module tb_pwm_capture;
    localparam int CS  = 4;
    localparam int NI  = 4;
    localparam int TOL = 1;
    localparam int IW  = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          run = 1'b0;
    logic [NI-1:0] pwm_in = '0;
    logic [IW-1:0] meas_output;
    logic [7:0]    meas_duty;
    logic          meas_error;
    logic          meas_valid;

    pwm_capture #(.CLK_SCALER(CS), .NB_INPUTS(NI), .PERIOD_TOL(TOL)) dut (
        .clk(clk), .rst(rst), .run(run), .pwm_in(pwm_in),
        .meas_output(meas_output), .meas_duty(meas_duty),
        .meas_error(meas_error), .meas_valid(meas_valid)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: sampled level history per channel since the last
    // window start (length and number of high samples).
    int            run_run;
    logic [NI-1:0] p1, p2;
    bit            prev_m[NI];
    bit            armed_m[NI];
    int            len_m[NI];
    int            ones_m[NI];
    bit            pend_m[NI];
    int            pduty_m[NI];
    bit            perr_m[NI];
    int            start_m;

    // Generator settings: period and high time in ticks, phase offset.
    int gcyc;
    int per_g[NI], high_g[NI], ph_g[NI];

    // Observations of DUT reports for directed checks.
    int rep_cnt[NI], last_duty[NI], last_cyc[NI];
    bit last_err[NI];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic clear_channels();
        for (int c = 0; c < NI; c++) begin
            prev_m[c] = 0; armed_m[c] = 0; len_m[c] = 0; ones_m[c] = 0;
            pend_m[c] = 0; pduty_m[c] = 0; perr_m[c] = 0;
        end
    endtask

    task automatic model_reset();
        clear_channels();
        start_m = 0; run_run = 0; p1 = '0; p2 = '0;
    endtask

    task automatic clear_obs();
        for (int c = 0; c < NI; c++) begin
            rep_cnt[c] = 0; last_duty[c] = -1; last_err[c] = 0; last_cyc[c] = 0;
        end
    endtask

    function automatic bit any_pending();
        bit a = 0;
        for (int c = 0; c < NI; c++) a |= pend_m[c];
        return a;
    endfunction

    task automatic emit(input int c, input int duty, input bit err);
        pend_m[c] = 1; pduty_m[c] = duty; perr_m[c] = err;
    endtask

    task automatic channel_tick(input int c, input bit s);
        if (!prev_m[c] && s) begin
            if (armed_m[c])
                emit(c, (ones_m[c] > 100) ? 100 : ones_m[c],
                     (len_m[c] < 100 - TOL) || (len_m[c] > 100 + TOL));
            len_m[c] = 1; ones_m[c] = 1; armed_m[c] = 1;
        end else if (len_m[c] + 1 > 100 + TOL) begin
            emit(c, s ? 100 : 0, 0);
            len_m[c] = 1; ones_m[c] = s ? 1 : 0; armed_m[c] = 0;
        end else begin
            len_m[c]++;
            if (s) ones_m[c]++;
        end
        prev_m[c] = s;
    endtask

    task automatic drive_pwm();
        int tk;
        tk = gcyc / CS;
        for (int c = 0; c < NI; c++) begin
            if (high_g[c] >= per_g[c])  pwm_in[c] = 1'b1;
            else if (high_g[c] == 0)    pwm_in[c] = 1'b0;
            else pwm_in[c] = (((tk + ph_g[c]) % per_g[c]) < high_g[c]);
        end
    endtask

    // One clock cycle: predict, advance, compare, update the model.
    task automatic step();
        bit            tick_n;
        logic [NI-1:0] s_n;
        bit            g_any;
        int            g;
        drive_pwm();
        s_n    = p2;
        tick_n = run && (run_run % CS == CS - 1);
        g_any  = 0;
        g      = 0;
        if (run) begin
            for (int k = 0; k < NI; k++) begin
                int idx;
                idx = (start_m + k) % NI;
                if (!g_any && pend_m[idx]) begin g_any = 1; g = idx; end
            end
        end
        @(posedge clk);
        #1;
        check("meas_valid", meas_valid, g_any);
        if (g_any) begin
            check("meas_output", meas_output, g);
            check("meas_duty", meas_duty, pduty_m[g]);
            check("meas_error", meas_error, perr_m[g]);
        end
        if (meas_valid === 1'b1 && !$isunknown(meas_output)) begin
            rep_cnt[meas_output]++;
            last_duty[meas_output] = meas_duty;
            last_err[meas_output]  = meas_error;
            last_cyc[meas_output]  = gcyc;
        end
        if (g_any) begin pend_m[g] = 0; start_m = (g + 1) % NI; end
        if (!run) clear_channels();
        else if (tick_n) for (int c = 0; c < NI; c++) channel_tick(c, s_n[c]);
        run_run = run ? run_run + 1 : 0;
        p2 = p1;
        p1 = pwm_in;
        gcyc++;
    endtask

    task automatic run_ticks(input int n);
        repeat (n * CS) step();
    endtask

    task automatic set_ch(input int c, input int per, input int high, input int ph);
        per_g[c] = per; high_g[c] = high; ph_g[c] = ph;
    endtask

    initial begin
        int d_r[NI];
        int guard;
        int lowv;
        int tbl[4][4];
        tbl = '{'{90, 45, 45, 1}, '{99, 50, 50, 0}, '{101, 30, 30, 0}, '{98, 97, 97, 1}};
        gcyc = 0;
        for (int c = 0; c < NI; c++) set_ch(c, 100, 0, 0);
        model_reset();
        clear_obs();

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", meas_valid, 0);
        check("rst_output", meas_output, 0);
        check("rst_duty", meas_duty, 0);
        check("rst_error", meas_error, 0);
        rst = 1'b1;
        run = 1'b1;

        // Aligned 20/40/60/80: reports in consecutive cycles, order 0..3
        for (int c = 0; c < NI; c++) set_ch(c, 100, 20 * (c + 1), 0);
        run_ticks(350);
        for (int c = 0; c < NI; c++) begin
            check("aligned_count", rep_cnt[c] >= 2, 1);
            check("aligned_duty", last_duty[c], 20 * (c + 1));
            check("aligned_err", last_err[c], 0);
        end
        for (int c = 1; c < NI; c++)
            check("aligned_rr_gap", last_cyc[c] - last_cyc[c - 1], 1);

        // Single channel at 60, others low
        for (int c = 1; c < NI; c++) set_ch(c, 100, 0, 0);
        set_ch(0, 100, 60, 0);
        clear_obs();
        run_ticks(450);
        check("ch0_60_count", rep_cnt[0] >= 3, 1);
        check("ch0_60_duty", last_duty[0], 60);
        check("ch0_60_err", last_err[0], 0);
        check("low_ch_duty", last_duty[3], 0);

        // Channel 2 held high, then held low
        set_ch(2, 100, 100, 0);
        clear_obs();
        run_ticks(350);
        check("ch2_high_count", rep_cnt[2] >= 2, 1);
        check("ch2_high_duty", last_duty[2], 100);
        check("ch2_high_err", last_err[2], 0);
        set_ch(2, 100, 0, 0);
        clear_obs();
        run_ticks(350);
        check("ch2_low_duty", last_duty[2], 0);
        check("ch2_low_err", last_err[2], 0);

        // Channel 1 with off-nominal periods
        for (int t = 0; t < 4; t++) begin
            set_ch(1, tbl[t][0], tbl[t][1], 0);
            clear_obs();
            run_ticks(400);
            check("ch1_period_duty", last_duty[1], tbl[t][2]);
            check("ch1_period_err", last_err[1], tbl[t][3]);
        end

        // Random duties and phases on all channels
        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < NI; c++) begin
                d_r[c] = $urandom_range(99, 1);
                set_ch(c, 100, d_r[c], $urandom_range(99, 0));
            end
            clear_obs();
            run_ticks(350);
            for (int c = 0; c < NI; c++) begin
                check("rand_duty", last_duty[c], d_r[c]);
                check("rand_err", last_err[c], 0);
            end
        end

        // Reset while a report is pending
        set_ch(0, 100, 60, 0);
        for (int c = 1; c < NI; c++) set_ch(c, 100, 0, 0);
        run_ticks(250);
        guard = 0;
        while (!any_pending() && guard < 2000) begin
            step();
            guard++;
        end
        check("pending_before_reset", any_pending(), 1);
        rst = 1'b0;
        #1;
        check("mid_rst_valid", meas_valid, 0);
        check("mid_rst_output", meas_output, 0);
        check("mid_rst_duty", meas_duty, 0);
        check("mid_rst_error", meas_error, 0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        model_reset();
        clear_obs();
        run_ticks(350);
        check("after_rst_duty", last_duty[0], 60);

        // run low for 10 clocks mid-period
        run_ticks(37);
        run  = 1'b0;
        lowv = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (i > 0 && meas_valid === 1'b1) lowv++;
        end
        check("no_report_run_low", lowv, 0);
        run = 1'b1;
        clear_obs();
        run_ticks(350);
        check("after_run_duty", last_duty[0], 60);
        check("after_run_err", last_err[0], 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
